// File: rtl/latch_input_conditioner.sv
// Input conditioning for the D-latch demo. It synchronizes and debounces the push button
// and slide switches, and produces enable level, press pulse, clean data and press count.
module latch_input_conditioner #(
    parameter int DEBOUNCE_CYCLES = 1_000_000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       btn1,
    input  logic [7:0] data,
    output logic       en,
    output logic       en_pulse,
    output logic [7:0] data_out,
    output logic [7:0] press_count
);

    // state        | meaning
    // IDLE         | button released, en = 0
    // PRESS_WAIT   | btn_s high, counting toward acceptance
    // HELD         | press accepted, en = 1
    // RELEASE_WAIT | btn_s low, counting toward release, en still 1
    typedef enum logic [1:0] {
        IDLE         = 2'd0,
        PRESS_WAIT   = 2'd1,
        HELD         = 2'd2,
        RELEASE_WAIT = 2'd3
    } state_t;

    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             btn_s1_q, btn_s_q;
    logic [7:0]       data_s1_q, data_s_q;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             en_q, en_d;
    logic             en_pulse_q, en_pulse_d;
    logic [7:0]       press_count_q, press_count_d;

    logic [CNT_W-1:0] dcnt_q, dcnt_d;
    logic [7:0]       data_prev_q, data_prev_d;
    logic [7:0]       data_out_q, data_out_d;

    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        en_pulse_d    = 1'b0;
        press_count_d = press_count_q;
        case (state_q)
            IDLE: begin
                if (btn_s_q) begin
                    state_d = PRESS_WAIT;
                    cnt_d   = '0;
                end
            end
            PRESS_WAIT: begin
                if (!btn_s_q) begin
                    state_d = IDLE;
                end else if (cnt_q != CNT_LAST) begin
                    cnt_d = cnt_q + CNT_W'(1);
                end else begin
                    state_d       = HELD;
                    en_pulse_d    = 1'b1;
                    press_count_d = press_count_q + 8'd1;
                end
            end
            HELD: begin
                if (!btn_s_q) begin
                    state_d = RELEASE_WAIT;
                    cnt_d   = '0;
                end
            end
            RELEASE_WAIT: begin
                if (btn_s_q) begin
                    state_d = HELD;
                end else if (cnt_q != CNT_LAST) begin
                    cnt_d = cnt_q + CNT_W'(1);
                end else begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
        // Registered copy of the state decode keeps en glitch-free for the latch.
        en_d = (state_d == HELD) || (state_d == RELEASE_WAIT);
    end

    always_comb begin
        data_prev_d = data_s_q;
        dcnt_d      = dcnt_q;
        data_out_d  = data_out_q;
        if (data_s_q != data_prev_q) begin
            dcnt_d = '0;
        end else if (dcnt_q != CNT_LAST) begin
            dcnt_d = dcnt_q + CNT_W'(1);
        end else begin
            data_out_d = data_s_q;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            btn_s1_q      <= 1'b0;
            btn_s_q       <= 1'b0;
            data_s1_q     <= 8'h00;
            data_s_q      <= 8'h00;
            state_q       <= IDLE;
            cnt_q         <= '0;
            en_q          <= 1'b0;
            en_pulse_q    <= 1'b0;
            press_count_q <= 8'h00;
            dcnt_q        <= '0;
            data_prev_q   <= 8'h00;
            data_out_q    <= 8'h00;
        end else begin
            btn_s1_q      <= btn1;
            btn_s_q       <= btn_s1_q;
            data_s1_q     <= data;
            data_s_q      <= data_s1_q;
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            en_q          <= en_d;
            en_pulse_q    <= en_pulse_d;
            press_count_q <= press_count_d;
            dcnt_q        <= dcnt_d;
            data_prev_q   <= data_prev_d;
            data_out_q    <= data_out_d;
        end
    end

    assign en          = en_q;
    assign en_pulse    = en_pulse_q;
    assign data_out    = data_out_q;
    assign press_count = press_count_q;

endmodule
